shifter_result_fifo: RTL
========================

# shifter_result_fifo

Downstream result buffer for the pipelined shifter I/O wrapper. The shifter path has a fixed latency and no backpressure. This block therefore captures every `v_out`/`dout` beat into a FIFO and presents it to the consumer over a valid/ready handshake. It also runs a credit counter (`issue_ok`) so the upstream issuer never launches more operations than the FIFO can absorb, counting beats still in flight through the shifter.

## Interface
- `WIDTH`, 16, data width; matches shifter `WIDTH`.
- `DEPTH`, 8, FIFO entries; power of two, ≥ 2.
- `CNT_W`, `$clog2(DEPTH+1)`, width of occupancy and in-flight counters (derived, not overridden).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `issue`  in  1  upstream launched one shifter op this cycle (same cycle it drives shifter `v_in`).
- `issue_ok`  out  1  a credit is available; upstream may assert `issue`.
- `v_in`  in  1  shifter result valid (shifter `v_out`).
- `din`  in  WIDTH  shifter result (shifter `dout`).
- `m_valid`  out  1  FIFO head valid.
- `m_ready`  in  1  consumer accepts the head.
- `m_data`  out  WIDTH  FIFO head data.
- `count`  out  CNT_W  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a beat was dropped while full.
- `proto_err`  out  1  sticky: `v_in` arrived with zero beats in flight.

## Operation
- Storage: `DEPTH` × `WIDTH` register array. `wr_ptr`/`rd_ptr` are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. `occ` counts 0..DEPTH.
- Push: `push = v_in && (occ < DEPTH || pop)`. A push writes `din` at `wr_ptr` and increments `wr_ptr`.
- Pop: `pop = m_valid && m_ready`. A pop increments `rd_ptr`.
- Occupancy: `occ` changes by push − pop, so it is unchanged on a simultaneous push and pop.
- Full with simultaneous pop and `v_in`: the beat is accepted and `occ` stays `DEPTH`.
- Full, `v_in`, no pop: the beat is dropped, `overflow` ← 1, pointers and `occ` unchanged.
- Empty with `m_ready`: no pop. `m_data` is don't-care and must not advance the pointers.
- Head outputs (first-word fall-through): `m_valid = (occ != 0)`; `m_data = mem[rd_ptr]`; `count = occ`.
- In-flight counter `infl`:
  - `+1` on `issue`, `−1` on `v_in`; both in the same cycle leaves it unchanged.
  - `v_in` with `infl == 0` and no `issue`: `proto_err` ← 1, `infl` stays 0 (floor).
  - `infl` saturates at `DEPTH`.
- Credit: `issue_ok = (occ + infl) < DEPTH`. It is computed combinationally from registered `occ`/`infl`, using an adder one bit wider than `CNT_W`.
- `issue` while `issue_ok == 0` is an upstream violation. It is still counted, and may later produce `overflow`.
- No FSM beyond the counters. Sticky flags clear only on `rst`.

## Timing
- Reset (async assert, sync release on `clk`) forces:
  - pointers, `occ` and `infl` to 0;
  - `m_valid` = 0, `count` = 0, `overflow` = 0, `proto_err` = 0, `issue_ok` = 1.
  - Memory contents are not reset.
- Latency `v_in` → `m_valid`: 1 cycle. A beat written at edge N is visible as head after edge N.
- Latency pop → next head: 1 cycle.
- Sustained rate: one push and one pop per cycle when `m_ready` is held high.
- `issue_ok` responds 1 cycle after the `issue`/`v_in`/pop that changes `occ + infl`.
- Safe operation: an issuer obeying `issue_ok`, with any shifter latency, never causes `overflow`.
- Reset mid-operation: in-flight shifter beats arriving after reset release decrement a zero `infl` and set `proto_err`. The system must therefore reset the shifter path together with this block.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle → `m_valid`=0, `count`=0, `issue_ok`=1, flags 0 immediately, without waiting for a clock edge.
- **Single beat:** `issue` at cycle 0, `v_in` with `din`=16'hA5C3 at cycle 4, `m_ready`=0 → `count`=1, `m_valid`=1, `m_data`=16'hA5C3 from cycle 5. With `m_ready`=1 at cycle 7 → `m_valid`=0 at cycle 8.
- **Credit throttle (`DEPTH`=8):** issue 8 ops back to back with `m_ready`=0 → `issue_ok` drops to 0 after the 8th `issue` while `infl`=8. It stays 0 when `count` reaches 8, and rises one cycle after the first pop.
- **Full + simultaneous push/pop:** fill to 8, then `v_in`=1 with `din`=16'h1234 and `m_ready`=1 in the same cycle → `count` stays 8, `overflow`=0, 16'h1234 is read out 8 pops later.
- **Overflow:** full, `m_ready`=0, force `v_in` with 16'hDEAD → `overflow`=1 (sticky), `count`=8, and 16'hDEAD never appears on `m_data`.
- **Wrap and order:** stream 20 beats 0x0000..0x0013 with random `m_ready` → output exactly in order, with pointers wrapped twice and no data loss.

Source files
------------

// File: rtl/shifter_result_fifo.sv
// Result buffer behind the fixed-latency shifter: FWFT FIFO plus an
// issue-credit counter that covers beats still in flight.
module shifter_result_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue,
    output logic             issue_ok,
    input  logic             v_in,
    input  logic [WIDTH-1:0] din,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    output logic             proto_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] occ_q, occ_d;
    logic [CNT_W-1:0] infl_q, infl_d;
    logic             ovf_q, ovf_d;
    logic             perr_q, perr_d;
    logic             push, pop, full;
    logic [CNT_W:0]   credit_sum;

    assign full    = (occ_q == FULL);
    assign m_valid = (occ_q != '0);
    assign pop     = m_valid && m_ready;
    assign push    = v_in && (!full || pop);

    assign m_data    = mem_q[rd_ptr_q];
    assign count     = occ_q;
    assign overflow  = ovf_q;
    assign proto_err = perr_q;

    // One extra bit so occ + infl can never wrap before the compare
    assign credit_sum = {1'b0, occ_q} + {1'b0, infl_q};
    assign issue_ok   = (credit_sum < (CNT_W+1)'(DEPTH));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        infl_d   = infl_q;
        ovf_d    = ovf_q;
        perr_d   = perr_q;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

        unique case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        if (v_in && !push) ovf_d = 1'b1;

        unique case ({issue, v_in})
            2'b10: begin
                if (infl_q != FULL) infl_d = infl_q + 1'b1;
            end
            2'b01: begin
                if (infl_q == '0) perr_d = 1'b1;
                else              infl_d = infl_q - 1'b1;
            end
            default: infl_d = infl_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            infl_q   <= '0;
            ovf_q    <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            infl_q   <= infl_d;
            ovf_q    <= ovf_d;
            perr_q   <= perr_d;
        end
    end

    // Storage is data-only, so it carries no reset
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

endmodule
